// File: rtl/puvvada_says_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// puvvada_says_pkg: seven-segment glyphs and converter states. Rev 1.0
// ---------------------------------------------------------------------------
package puvvada_says_pkg;

  // Active-low segments {a,b,c,d,e,f,g}, a is the MSB
  localparam logic [6:0] SSD_0     = 7'b0000001;
  localparam logic [6:0] SSD_1     = 7'b1001111;
  localparam logic [6:0] SSD_2     = 7'b0010010;
  localparam logic [6:0] SSD_3     = 7'b0000110;
  localparam logic [6:0] SSD_4     = 7'b1001100;
  localparam logic [6:0] SSD_5     = 7'b0100100;
  localparam logic [6:0] SSD_6     = 7'b0100000;
  localparam logic [6:0] SSD_7     = 7'b0001111;
  localparam logic [6:0] SSD_8     = 7'b0000000;
  localparam logic [6:0] SSD_9     = 7'b0001100;
  localparam logic [6:0] SSD_BLANK = 7'b1111111;
  localparam logic [6:0] SSD_L     = 7'b1110001;
  localparam logic [6:0] SSD_P     = 7'b0011000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } conv_state_t;

  function automatic logic [6:0] ssd_encode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SSD_0;
      4'd1:    return SSD_1;
      4'd2:    return SSD_2;
      4'd3:    return SSD_3;
      4'd4:    return SSD_4;
      4'd5:    return SSD_5;
      4'd6:    return SSD_6;
      4'd7:    return SSD_7;
      4'd8:    return SSD_8;
      4'd9:    return SSD_9;
      default: return SSD_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/puvvada_says_ssd_driver_bin2bcd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin2bcd_seq: multi-cycle shift-add-3 binary to 3-digit BCD engine. Rev 1.0
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import puvvada_says_pkg::*;
#(
  parameter int BIN_W = 9
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [11:0]      bcd,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state, state_nx;
  logic [BIN_W-1:0] bin_q;
  logic [11:0]      bcd_q;
  logic [11:0]      bcd_adj;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        LOAD: begin
          bin_q <= bin;
          bcd_q <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt            <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state != IDLE);
  assign done = (state == COMMIT);

endmodule
`default_nettype wire

// File: rtl/puvvada_says_ssd_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// puvvada_says_ssd_driver: level/score to BCD, multiplexed onto 4 SSDs. Rev 1.0
// ---------------------------------------------------------------------------
module puvvada_says_ssd_driver
  import puvvada_says_pkg::*;
#(
  parameter int SCAN_BITS = 18,
  parameter int BIN_W     = 9
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [6:0] level,
  input  logic [8:0] score,
  input  logic       Show_score,
  output logic       An3,
  output logic       An2,
  output logic       An1,
  output logic       An0,
  output logic [6:0] Cathodes,
  output logic       Dp,
  output logic       Conv_busy
);

  logic [BIN_W-1:0]     sel;
  logic [BIN_W-1:0]     last_val;
  logic                 last_mode;
  logic                 start;
  logic                 load_q;
  logic                 busy;
  logic                 done;
  logic [11:0]          bcd;
  logic [3:0]           d2, d1, d0;
  logic                 mode_q;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [1:0]           sel2;
  logic [3:0]           an_nx, an_q;
  logic [6:0]           cath_nx, cath_q;

  assign sel   = Show_score ? BIN_W'(score) : BIN_W'(level);
  assign start = (sel != last_val) || (Show_score != last_mode);

  bin2bcd_seq #(.BIN_W(BIN_W)) u_bin2bcd (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start),
    .bin     (sel),
    .bcd     (bcd),
    .busy    (busy),
    .done    (done)
  );

  // load_q marks the engine's LOAD cycle, when it samples the same sel we record here
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      load_q    <= 1'b0;
      last_val  <= '0;
      last_mode <= 1'b0;
      d2        <= 4'd0;
      d1        <= 4'd0;
      d0        <= 4'd0;
      mode_q    <= 1'b0;
    end else begin
      load_q <= start && !busy;
      if (load_q) begin
        last_val  <= sel;
        last_mode <= Show_score;
      end
      if (done) begin
        {d2, d1, d0} <= bcd;
        mode_q       <= last_mode;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) scan_cnt <= '0;
    else          scan_cnt <= scan_cnt + SCAN_BITS'(1);
  end

  assign sel2 = scan_cnt[SCAN_BITS-1 -: 2];

  always_comb begin
    an_nx   = 4'b1111;
    cath_nx = SSD_BLANK;
    case (sel2)
      2'd0: begin
        an_nx   = 4'b1110;
        cath_nx = ssd_encode(d0);
      end
      2'd1: begin
        an_nx   = 4'b1101;
        cath_nx = (d2 == 4'd0 && d1 == 4'd0) ? SSD_BLANK : ssd_encode(d1);
      end
      2'd2: begin
        an_nx   = 4'b1011;
        cath_nx = (d2 == 4'd0) ? SSD_BLANK : ssd_encode(d2);
      end
      default: begin
        an_nx   = 4'b0111;
        cath_nx = mode_q ? SSD_P : SSD_L;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      an_q   <= 4'b1110;
      cath_q <= SSD_0;
    end else begin
      an_q   <= an_nx;
      cath_q <= cath_nx;
    end
  end

  assign {An3, An2, An1, An0} = an_q;
  assign Cathodes             = cath_q;
  assign Dp                   = 1'b1;
  assign Conv_busy            = busy;

endmodule
`default_nettype wire

// File: doc/puvvada_says_ssd_driver.md
# puvvada_says_ssd_driver

Display stage directly downstream of the game state machine in the puvvada_says design. It takes the binary `level` (7-bit) and `score` (9-bit) values and converts the selected one to three BCD digits with a multi-cycle shift-add-3 (double-dabble) engine. It then time-multiplexes a mode letter and the digits onto the four active-low seven-segment displays An3..An0. It replaces the combinational hex-split logic in the top level.

## Interface
Parameters:
- `SCAN_BITS`, default 18: width of the free-running scan counter; digit select = counter[SCAN_BITS-1:SCAN_BITS-2].
- `BIN_W`, default 9: conversion input width; `level` is zero-extended to it.

Ports:
- `Clk`, input, 1: system clock (board clock).
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `level`, input, 7: current level from the SM.
- `score`, input, 9: current score from the SM.
- `Show_score`, input, 1: 0 = display level, 1 = display score.
- `An3`..`An0`, output, 1 each: digit anodes, active-low.
- `Cathodes`, output, 7: segments {a,b,c,d,e,f,g} with a as MSB, active-low.
- `Dp`, output, 1: decimal point, held 1 (off).
- `Conv_busy`, output, 1: high while a conversion is in progress.

## Operation
- Selected value `sel` = Show_score ? score : {2'b0, level}.
- Converter FSM states and transitions:
  - IDLE → LOAD when `sel` ≠ `last_val` or `Show_score` ≠ `last_mode`.
  - LOAD: capture `sel` into the shift register, clear the 12-bit BCD accumulator, and record `last_val` / `last_mode`.
  - SHIFT: runs BIN_W cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - COMMIT: copy the accumulator to the display registers `d2 d1 d0` and `mode_q` in one cycle, then go to IDLE.
- Display registers change only in COMMIT. Partial results are never shown.
- Input changes during LOAD, SHIFT or COMMIT are ignored by the running conversion. They are caught by the IDLE comparison afterwards, so a new conversion starts one cycle after COMMIT.
- Maximum value 511 fits in 3 digits. No saturation or overflow case exists.
- Scan counter (SCAN_BITS wide) increments every cycle and wraps naturally. Digit select `sel2` drives the displays as follows:
  - 00 → An0 shows d0, always lit.
  - 01 → An1 shows d1, blanked (cathodes 7'b1111111) if d2 = 0 and d1 = 0.
  - 10 → An2 shows d2, blanked if d2 = 0.
  - 11 → An3 shows the mode letter: 'L' = 7'b1110001 when mode_q = 0, 'P' = 7'b0011000 when mode_q = 1.
- Exactly one anode is low at a time. An3..An0 and Cathodes are registered from `sel2` and the digits, so they change on the same edge.
- Digit encoding 0–9 (active-low a..g):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0001100
  - Nibbles 10–15 are unreachable; they map to blank.

## Timing
- Conversion latency: 1 (LOAD) + BIN_W (SHIFT) + 1 (COMMIT) = 11 cycles from the IDLE edge detecting a change to the display registers updating.
- `Conv_busy` is high from the LOAD cycle through the COMMIT cycle inclusive, 11 cycles.
- Each digit is held for 2^(SCAN_BITS-2) cycles: 65 536 at default, 0.66 ms at 100 MHz.
- Reset values (asynchronous, while Reset_n = 0):
  - FSM = IDLE, scan counter = 0, d2/d1/d0 = 0, mode_q = 0, last_val = 0, last_mode = 0.
  - An0 = 0, An1..An3 = 1, Cathodes = 7'b0000001, Conv_busy = 0, Dp = 1.
- Reset asserted mid-conversion aborts it immediately. After release, the first cycle re-evaluates `sel` against last_val = 0.
- A `Show_score` toggle with an equal numeric value still triggers a conversion, so the mode letter updates.

## Structure
- Shared package `puvvada_says_pkg` holds:
  - seven-segment digit constants `SSD_0`..`SSD_9`, plus `SSD_BLANK`, `SSD_L` and `SSD_P`;
  - the converter state typedef / localparams (IDLE, LOAD, SHIFT, COMMIT).
- Sub-module `bin2bcd_seq` contains the LOAD/SHIFT/COMMIT engine with ports `Clk`, `Reset_n`, `start`, `bin[BIN_W-1:0]`, `bcd[11:0]`, `busy` and `done`.
- The top of this block holds the change detection, the scan counter and the segment encoding.

## Test plan
- Reset held, then released with level = 0 and Show_score = 0 → no conversion (`Conv_busy` stays 0); scan shows An0 = '0', An1 and An2 blank, An3 = 'L'.
- level = 7'd57 → `Conv_busy` goes high for exactly 11 cycles; then d2/d1/d0 = 0/5/7, An1 shows 0100100, An2 is blank.
- Show_score = 1 with score = 9'd511 → digits 5, 1, 1, An3 = 'P'; An2 shows 0100100.
- level changes 12 → 99 during SHIFT → display shows 12 after the first COMMIT; a second conversion starts 1 cycle later and the display shows 99 11 cycles after that.
- Reset_n pulsed low at SHIFT cycle 4 of a 300 conversion → outputs take their reset values asynchronously; after release the display converges to 300 in 12 cycles (1 detection cycle + 11).
- SCAN_BITS = 4 → anode sequence An0, An1, An2, An3 each low for 4 cycles and wrapping; never 0 or ≥ 2 anodes low at once.
